// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the instruction-memory loader.
package prog_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

  // StCheck is only reachable when the checksum feature is compiled in.
  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StCheck,
    StDone
  } state_e;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// prog_loader_word_assembler: packs accepted stream bytes into a little-endian word.
// Byte k of a word lands in bits [8k+7:8k]. With PROG_LOADER_CHECKSUM_EN defined it also
// keeps a mod-256 running sum of every data byte and compares it to the current byte.
module prog_loader_word_assembler
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              data_xfer,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_full
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic              sum_match
`endif
);

  localparam logic [BCNT_W-1:0] LastByte = BCNT_W'(BYTES_PER_WORD - 1);

  logic [BCNT_W-1:0] bcnt_q;
  logic [WORD_W-1:0] word_q;

  // Byte counter and shift register; new bytes enter at the top so byte 0 ends at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= '0;
      word_q <= '0;
    end else if (clr) begin
      bcnt_q <= '0;
    end else if (data_xfer) begin
      bcnt_q <= bcnt_q + 1'b1;
      word_q <= {byte_data, word_q[WORD_W-1:BYTE_W]};
    end
  end

  // Strobe for the transfer that completes a word; the counter wraps to 0 on it.
  assign word_full = data_xfer && (bcnt_q == LastByte);
  assign word      = word_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum_q;

  // Running checksum of data bytes only; the checksum byte itself is never accumulated.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum_q <= '0;
    end else if (data_xfer) begin
      sum_q <= sum_q + byte_data;
    end
  end

  assign sum_match = (byte_data == sum_q);
`endif

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads instruction memory from a byte stream over a valid/ready handshake,
// writing 32-bit little-endian words sequentially from address 0 while holding the CPU
// in reset. Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte;
// a mismatch sets a sticky err that keeps the CPU in reset until the next start or rst.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e          state_q;
  logic [ADDR_W:0] words_left_q;
  logic            xfer;
  logic            data_xfer;
  logic            clr;
  logic            word_full;
  logic            last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic            sum_match;
  logic            err_q;
`endif

  // byte_ready is only ever high in RECV/CHECK, so stray valids elsewhere never transfer.
  assign xfer      = byte_valid & byte_ready;
  assign data_xfer = xfer & (state_q == StRecv);
  assign clr       = (state_q == StIdle) & start;
  assign last_word = (words_left_q == (ADDR_W + 1)'(1));

  prog_loader_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .data_xfer (data_xfer),
    .byte_data (byte_data),
    .word      (imem_wdata),
    .word_full (word_full)
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    .sum_match (sum_match)
`endif
  );

  // Session FSM with registered handshake/strobe outputs and the address/word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      byte_ready   <= 1'b0;
      imem_we      <= 1'b0;
      done         <= 1'b0;
      imem_addr    <= '0;
      words_left_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      err_q        <= 1'b0;
`endif
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            imem_addr    <= '0;
            words_left_q <= word_count;
`ifdef PROG_LOADER_CHECKSUM_EN
            err_q        <= 1'b0;
`endif
            if (word_count == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_q    <= StCheck;
              byte_ready <= 1'b1;
`else
              state_q    <= StDone;
              done       <= 1'b1;
`endif
            end else begin
              state_q    <= StRecv;
              byte_ready <= 1'b1;
            end
          end
        end
        StRecv: begin
          if (word_full) begin
            state_q    <= StWrite;
            byte_ready <= 1'b0;
            imem_we    <= 1'b1;
          end
        end
        StWrite: begin
          // Address advances after the write; it can only wrap on the final word.
          imem_addr    <= imem_addr + 1'b1;
          words_left_q <= words_left_q - 1'b1;
          if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_q    <= StCheck;
            byte_ready <= 1'b1;
`else
            state_q    <= StDone;
            done       <= 1'b1;
`endif
          end else begin
            state_q    <= StRecv;
            byte_ready <= 1'b1;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        StCheck: begin
          if (xfer) begin
            byte_ready <= 1'b0;
            if (sum_match) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StIdle;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy    = (state_q != StIdle);
  assign cpu_rst = rst | busy | err;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven load sessions plus hand-written reset and checksum sequences.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [10:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  prog_loader #(
    .ADDR_W (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Session vector: stream byte k sits at bits [8k+7:8k]; lat is the negedge index
  // (1 = first negedge after the start-accept edge) where done is expected.
  typedef struct packed {
    logic [10:0] wc;
    logic [63:0] stream;
    logic        stall;
    logic [7:0]  lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one session from IDLE over a fixed 25-cycle window and checks writes and timing.
  task automatic run_session(input string name, input vec_t v, input bit bad_sum);
    int          nbytes;
    int          sent;
    int          nwr;
    int          done_k;
    int          n_done;
    int          busy_cyc;
    int          cpu_low;
    logic [7:0]  sum;
    logic [79:0] s;
    sum = 8'h00;
    for (int i = 0; i < 4 * int'(v.wc); i++) sum = sum + v.stream[8*i +: 8];
    s = {16'h0000, v.stream};
    nbytes = 4 * int'(v.wc) + CS;
    if (CS == 1) s[8*(nbytes-1) +: 8] = bad_sum ? sum + 8'd1 : sum;
    sent = 0; nwr = 0; done_k = -1; n_done = 0; busy_cyc = 0; cpu_low = 0;
    start = 1'b1;
    word_count = v.wc;
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      if (imem_we) begin
        if (nwr < 2) begin
          check({name, " addr"}, 32'(imem_addr), nwr);
          check({name, " wdata"}, imem_wdata, v.stream[32*nwr +: 32]);
        end
        nwr++;
      end
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (busy) busy_cyc++;
      if (busy && !cpu_rst) cpu_low++;
      byte_valid = (sent < nbytes) && (!v.stall || (k % 2 == 0));
      byte_data  = (sent < nbytes) ? s[8*sent +: 8] : 8'h00;
      if (byte_valid && byte_ready) sent++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    check({name, " writes"}, nwr, 32'(v.wc));
    check({name, " done_cycle"}, done_k, bad_sum ? 32'hFFFF_FFFF : 32'(v.lat));
    check({name, " done_pulses"}, n_done, bad_sum ? 32'd0 : 32'd1);
    check({name, " busy_cycles"}, busy_cyc, bad_sum ? 32'(v.lat) - 32'd1 : 32'(v.lat));
    check({name, " cpu_rst_low_while_busy"}, cpu_low, 32'd0);
    check({name, " err_end"}, 32'(err), bad_sum ? 32'd1 : 32'd0);
    check({name, " cpu_rst_end"}, 32'(cpu_rst), bad_sum ? 32'd1 : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] s;
    int          sent;
    int          nwr;
    int          n_done;
    vec_t        v;

    vecs[0] = '{wc: 11'd2, stream: 64'hDEAD_BEEF_1234_5678, stall: 1'b0, lat: 8'(11 + CS)};
    vecs[1] = '{wc: 11'd1, stream: 64'h0000_0000_A1B2_C3D4, stall: 1'b1, lat: 8'(10 + CS)};
    vecs[2] = '{wc: 11'd0, stream: 64'h0000_0000_0000_0000, stall: 1'b0, lat: 8'(1 + CS)};
    vecs[3] = '{wc: 11'd2, stream: 64'h0807_0605_0403_0201, stall: 1'b0, lat: 8'(11 + CS)};
    vecs[4] = '{wc: 11'd1, stream: 64'h0000_0000_5566_7788, stall: 1'b0, lat: 8'(6 + CS)};

    rst = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(negedge clk);
    check("rst byte_ready", 32'(byte_ready), 32'd0);
    check("rst imem_we", 32'(imem_we), 32'd0);
    check("rst imem_addr", 32'(imem_addr), 32'd0);
    check("rst imem_wdata", imem_wdata, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst cpu_rst", 32'(cpu_rst), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle cpu_rst", 32'(cpu_rst), 32'd0);
    check("idle busy", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) run_session($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Reset after five bytes: word 0 is written, the fifth byte is abandoned.
    s = 64'h0000_00AA_4433_2211;
    sent = 0; nwr = 0; n_done = 0;
    start = 1'b1;
    word_count = 11'd2;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (imem_we) begin
        check("midrst addr", 32'(imem_addr), 32'd0);
        check("midrst wdata", imem_wdata, 32'h4433_2211);
        nwr++;
      end
      if (done) n_done++;
      if (k == 7) rst = 1'b1;
      byte_valid = (sent < 5) && !rst;
      byte_data  = s[8*sent +: 8];
      if (byte_valid && byte_ready) sent++;
      @(negedge clk);
    end
    check("midrst bytes_sent", sent, 32'd5);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst byte_ready", 32'(byte_ready), 32'd0);
    check("midrst imem_addr", 32'(imem_addr), 32'd0);
    check("midrst cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst err", 32'(err), 32'd0);
    rst = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    check("midrst done_pulses", n_done + 32'(done), 32'd0);
    check("midrst writes", nwr, 32'd1);
    run_session("after_rst", vecs[4], 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    run_session("cs_bad", vecs[3], 1'b1);
    repeat (3) @(negedge clk);
    check("cs_bad cpu_rst_held", 32'(cpu_rst), 32'd1);
    check("cs_bad err_held", 32'(err), 32'd1);
    v = vecs[2];
    run_session("cs_recover", v, 1'b0);
`else
    v = vecs[2];
    run_session("zero_again", v, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
